// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 host transmitter and receive path.
// Contents: transmitter state enum, common command/response bytes, frame edge count,
// and the odd-parity helper used when latching a command byte.
package ps2_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StInhibit,
    StRts,
    StShift,
    StAck,
    StRecover
  } ps2_tx_state_e;

  localparam logic [7:0] PS2_CMD_RESET   = 8'hFF;
  localparam logic [7:0] PS2_CMD_SET_LED = 8'hED;
  localparam logic [7:0] PS2_CMD_ENABLE  = 8'hF4;
  localparam logic [7:0] PS2_RSP_ACK     = 8'hFA;

  // Device clock falling edges in one host-to-device frame (8 data, parity, stop, ack).
  localparam int unsigned PS2_FRAME_EDGES = 11;

  // Parity bit that makes the 9-bit {parity, data} word contain an odd number of ones.
  function automatic logic odd_parity(input logic [7:0] data);
    return ~^data;
  endfunction

endpackage

// File: rtl/ps2_host_tx_if.sv
// Command handshake between a requester and the PS/2 host transmitter.
// Signals: tx_data/tx_valid (request), tx_ready (accepting), busy (transfer in flight),
// tx_done (byte sent and acknowledged), tx_err (NACK or watchdog expiry).
// master: requester side; slave: transmitter side.
interface ps2_host_tx_if;

  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       busy;
  logic       tx_done;
  logic       tx_err;

  modport master (
    output tx_data, tx_valid,
    input  tx_ready, busy, tx_done, tx_err
  );

  modport slave (
    input  tx_data, tx_valid,
    output tx_ready, busy, tx_done, tx_err
  );

endinterface

// File: rtl/ps2_line_sync.sv
// Two-flop synchronizers for the PS/2 clock and data lines plus a one-cycle pulse on
// each synchronized PS2_CLK falling edge. Shared by the transmit and receive paths.
// Ports:
//   clk, rst        system clock, asynchronous active-low reset
//   ps2_clk_in      raw PS2_CLK pin level
//   ps2_data_in     raw PS2_DATA pin level
//   ps2_clk_sync    synchronized PS2_CLK
//   ps2_data_sync   synchronized PS2_DATA
//   ps2_clk_fall    high for one cycle when synchronized PS2_CLK goes 1 -> 0
module ps2_line_sync (
  input  logic clk,
  input  logic rst,
  input  logic ps2_clk_in,
  input  logic ps2_data_in,
  output logic ps2_clk_sync,
  output logic ps2_data_sync,
  output logic ps2_clk_fall
);

  // clk_pipe_q[1] is the synchronized level, clk_pipe_q[2] its previous value.
  logic [2:0] clk_pipe_q;
  logic [1:0] data_pipe_q;

  // Idle bus is high, so reset to 1 to avoid a spurious edge after reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      clk_pipe_q  <= '1;
      data_pipe_q <= '1;
    end else begin
      clk_pipe_q  <= {clk_pipe_q[1:0], ps2_clk_in};
      data_pipe_q <= {data_pipe_q[0], ps2_data_in};
    end
  end

  assign ps2_clk_sync  = clk_pipe_q[1];
  assign ps2_data_sync = data_pipe_q[1];
  assign ps2_clk_fall  = clk_pipe_q[2] & ~clk_pipe_q[1];

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: sends one command byte with the request-to-send
// sequence, odd parity and device acknowledge. Lines are only ever pulled low or released.
// Ports:
//   clk, rst   system clock, asynchronous active-low reset
//   tx         ps2_host_tx_if.slave: tx_data/tx_valid in; tx_ready/busy/tx_done/tx_err out
//   PS2_CLK    open-drain clock line (0 or Z)
//   PS2_DATA   open-drain data line (0 or Z)
// Parameters: INHIBIT_CYCLES (clock-low time before start), TIMEOUT_CYCLES (watchdog).
// Build option: define PS2_TX_TIMEOUT_EN to enable the per-transfer watchdog; without it
// the block waits indefinitely for the device and tx_err reports NACK only.
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int unsigned INHIBIT_CYCLES = 10000,
  parameter int unsigned TIMEOUT_CYCLES = 2000000
) (
  input  logic         clk,
  input  logic         rst,
  ps2_host_tx_if.slave tx,
  inout  wire          PS2_CLK,
  inout  wire          PS2_DATA
);

  localparam int unsigned CntMax =
      (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
  localparam int unsigned CntW = $clog2(CntMax + 1);

  typedef logic [CntW-1:0] cnt_t;

  localparam cnt_t       InhibitLast = cnt_t'(INHIBIT_CYCLES);
  localparam cnt_t       CntTop      = cnt_t'(CntMax);
  localparam logic [3:0] StopEdge    = 4'(PS2_FRAME_EDGES - 1);
`ifdef PS2_TX_TIMEOUT_EN
  localparam cnt_t       TimeoutLast = cnt_t'(TIMEOUT_CYCLES - 1);
`endif

  ps2_tx_state_e state_q, state_d;
  cnt_t          cnt_q, cnt_d;
  logic [3:0]    edge_q, edge_d;
  logic [8:0]    shift_q, shift_d;
  logic          bit_q, bit_d;

  logic clk_sync, data_sync, clk_fall;
  logic clk_low, data_low;
  logic done_pulse, err_pulse;

  ps2_line_sync u_line_sync (
    .clk          (clk),
    .rst          (rst),
    .ps2_clk_in   (PS2_CLK),
    .ps2_data_in  (PS2_DATA),
    .ps2_clk_sync (clk_sync),
    .ps2_data_sync(data_sync),
    .ps2_clk_fall (clk_fall)
  );

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    edge_d     = edge_q;
    shift_d    = shift_q;
    bit_d      = bit_q;
    clk_low    = 1'b0;
    data_low   = 1'b0;
    done_pulse = 1'b0;
    err_pulse  = 1'b0;

    // One counter times the inhibit phase and the watchdog; it saturates when unused.
    if (state_q != StIdle && cnt_q != CntTop) begin
      cnt_d = cnt_q + cnt_t'(1);
    end

    case (state_q)
      StIdle: begin
        if (tx.tx_valid) begin
          state_d = StInhibit;
          cnt_d   = '0;
          edge_d  = '0;
          shift_d = {odd_parity(tx.tx_data), tx.tx_data};
          bit_d   = 1'b1;
        end
      end
      StInhibit: begin
        clk_low = 1'b1;
        // Last inhibit cycle: data falls while clock is still held, clock released next.
        if (cnt_q == InhibitLast) begin
          data_low = 1'b1;
          state_d  = StRts;
        end
      end
      StRts: begin
        data_low = 1'b1;
        if (clk_fall) begin
          edge_d  = 4'd1;
          bit_d   = shift_q[0];
          state_d = StShift;
        end
      end
      StShift: begin
        data_low = ~bit_q;
        if (clk_fall) begin
          edge_d = edge_q + 4'd1;
          // edge_q holds the previous edge number; the bit for edge k is shift_q[k-1].
          if (edge_q == StopEdge - 4'd1) begin
            bit_d   = 1'b1;
            state_d = StAck;
          end else begin
            bit_d = shift_q[edge_q];
          end
        end
      end
      StAck: begin
        if (clk_fall) begin
          edge_d = edge_q + 4'd1;
          if (data_sync) begin
            err_pulse = 1'b1;
            state_d   = StIdle;
          end else begin
            state_d = StRecover;
          end
        end
      end
      StRecover: begin
        if (clk_sync && data_sync) begin
          done_pulse = 1'b1;
          state_d    = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

`ifdef PS2_TX_TIMEOUT_EN
    // Watchdog overrides everything else so done and err can never coincide.
    if (state_q != StIdle && cnt_q == TimeoutLast) begin
      state_d    = StIdle;
      clk_low    = 1'b0;
      data_low   = 1'b0;
      done_pulse = 1'b0;
      err_pulse  = 1'b1;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      edge_q  <= '0;
      shift_q <= '0;
      bit_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      edge_q  <= edge_d;
      shift_q <= shift_d;
      bit_q   <= bit_d;
    end
  end

  // Drive enables decode from async-reset state, so reset releases the lines at once.
  assign PS2_CLK  = clk_low  ? 1'b0 : 1'bz;
  assign PS2_DATA = data_low ? 1'b0 : 1'bz;

  assign tx.tx_ready = (state_q == StIdle);
  assign tx.busy     = (state_q != StIdle);
  assign tx.tx_done  = done_pulse;
  assign tx.tx_err   = err_pulse;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Self-checking bench for ps2_host_tx: a pulled-up open-drain bus, a device model that
// clocks frames and ACKs or NACKs, and a per-cycle compare against a behavioural model.
module tb_ps2_host_tx;
  import ps2_pkg::*;

  localparam int unsigned INH  = 2000;
  localparam int unsigned TO   = 4000;
  localparam int unsigned HALF = 20;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  wire  ps2_clk;
  wire  ps2_data;
  logic dev_clk_low  = 1'b0;
  logic dev_data_low = 1'b0;
  pullup (ps2_clk);
  pullup (ps2_data);
  assign ps2_clk  = dev_clk_low  ? 1'b0 : 1'bz;
  assign ps2_data = dev_data_low ? 1'b0 : 1'bz;

  ps2_host_tx_if tx_if ();

  ps2_host_tx #(
    .INHIBIT_CYCLES(INH),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .tx      (tx_if),
    .PS2_CLK (ps2_clk),
    .PS2_DATA(ps2_data)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic fail_bound(input string name);
    n_checks++;
    $display("FAIL %s: wait bound expired (t=%0t)", name, $time);
  endtask

  // Frame as the device sees it on edges 1..10: data LSB first, odd parity, stop.
  function automatic logic [9:0] exp_frame(input logic [7:0] b);
    logic par;
    par = (($countones(b) % 2) == 0);
    return {1'b1, par, b};
  endfunction

  // Behavioural model: busy from acceptance until the cycle after a result pulse;
  // m_cyc counts cycles since acceptance (1 = first cycle after the accepting edge).
  logic m_busy      = 1'b0;
  int   m_cyc       = 0;
  logic pulse_seen  = 1'b0;
  int   cnt_done    = 0;
  int   cnt_err     = 0;
  int   err_cyc     = -1;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_busy <= 1'b0;
      m_cyc  <= 0;
    end else if (!m_busy) begin
      if (tx_if.tx_valid) begin
        m_busy <= 1'b1;
        m_cyc  <= 1;
      end
    end else if (pulse_seen) begin
      m_busy <= 1'b0;
      m_cyc  <= 0;
    end else begin
      m_cyc <= m_cyc + 1;
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      check("busy", tx_if.busy, m_busy);
      check("tx_ready", tx_if.tx_ready, !m_busy);
      check("done_err_excl", tx_if.tx_done & tx_if.tx_err, 0);
      if (tx_if.tx_done) cnt_done++;
      if (tx_if.tx_err) begin
        cnt_err++;
        err_cyc = m_cyc;
      end
      // Inhibit: clock low INH cycles, then data low, then clock released.
      if (m_busy && m_cyc >= 1 && m_cyc <= int'(INH) + 2) begin
        check("rts_clk", ps2_clk, (m_cyc <= int'(INH) + 1) ? 0 : 1);
        check("rts_data", ps2_data, (m_cyc <= int'(INH)) ? 1 : 0);
      end
      pulse_seen <= tx_if.tx_done | tx_if.tx_err;
    end else begin
      pulse_seen <= 1'b0;
    end
  end

  task automatic send(input logic [7:0] b);
    @(posedge clk);
    #1 tx_if.tx_data = b;
    tx_if.tx_valid = 1'b1;
    @(posedge clk);
    #1 tx_if.tx_valid = 1'b0;
  endtask

  // Device: wait for request-to-send, then clock n_edges pulses, sampling the host's
  // bit at the end of each low phase; on edge 11 optionally pull data low (ACK).
  task automatic dev_xfer(input int n_edges, input bit ack, output logic [9:0] got,
                          output int inh_len);
    int waited;
    waited  = 0;
    got     = '0;
    inh_len = 0;
    while (!(ps2_clk === 1'b1 && ps2_data === 1'b0) && waited < int'(INH) + 100) begin
      @(negedge clk);
      if (ps2_clk === 1'b0 && ps2_data === 1'b1) inh_len++;
      waited++;
    end
    if (waited >= int'(INH) + 100) begin
      fail_bound("rts_wait");
      return;
    end
    @(posedge clk);
    #1;
    for (int k = 1; k <= n_edges; k++) begin
      if (k == 11 && ack) begin
        dev_data_low = 1'b1;
        repeat (5) @(posedge clk);
        #1;
      end
      dev_clk_low = 1'b1;
      repeat (HALF) @(posedge clk);
      #1;
      if (k <= 10) got[k-1] = ps2_data;
      dev_clk_low = 1'b0;
      repeat (HALF) @(posedge clk);
      #1;
    end
    dev_data_low = 1'b0;
  endtask

  task automatic finish_xfer(input string tag, input int done0, input int err0,
                             input int exp_done, input int exp_err);
    int w;
    w = 0;
    while (!tx_if.tx_ready && w < 100) begin
      @(negedge clk);
      w++;
    end
    if (w >= 100) fail_bound({tag, "_ready_wait"});
    repeat (4) @(negedge clk);
    check({tag, "_done_cnt"}, cnt_done - done0, exp_done);
    check({tag, "_err_cnt"}, cnt_err - err0, exp_err);
    check({tag, "_clk_rel"}, ps2_clk, 1);
    check({tag, "_data_rel"}, ps2_data, 1);
  endtask

  logic [9:0] got;
  int         inh;
  int         d0, e0;

  initial begin
    tx_if.tx_valid = 1'b0;
    tx_if.tx_data  = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", tx_if.tx_ready, 1);
    check("rst_busy", tx_if.busy, 0);
    check("rst_done", tx_if.tx_done, 0);
    check("rst_err", tx_if.tx_err, 0);
    check("rst_clk", ps2_clk, 1);
    check("rst_data", ps2_data, 1);
    rst = 1'b1;
    repeat (2) @(posedge clk);

    // Set-LEDs command, ACKed.
    d0 = cnt_done; e0 = cnt_err;
    send(PS2_CMD_SET_LED);
    dev_xfer(11, 1'b1, got, inh);
    check("ed_inhibit_len", inh, INH);
    check("ed_frame_lit", got, 10'h3ED);
    check("ed_frame_model", got, exp_frame(PS2_CMD_SET_LED));
    finish_xfer("ed", d0, e0, 1, 0);

    // Reset command (all ones).
    d0 = cnt_done; e0 = cnt_err;
    send(PS2_CMD_RESET);
    dev_xfer(11, 1'b1, got, inh);
    check("ff_frame_lit", got, 10'h3FF);
    check("ff_frame_model", got, exp_frame(PS2_CMD_RESET));
    finish_xfer("ff", d0, e0, 1, 0);

    // All zeros.
    d0 = cnt_done; e0 = cnt_err;
    send(8'h00);
    dev_xfer(11, 1'b1, got, inh);
    check("z00_frame_lit", got, 10'h300);
    check("z00_frame_model", got, exp_frame(8'h00));
    finish_xfer("z00", d0, e0, 1, 0);

    // NACK: device leaves data high on edge 11.
    d0 = cnt_done; e0 = cnt_err;
    send(8'h12);
    dev_xfer(11, 1'b0, got, inh);
    check("nack_frame_model", got, exp_frame(8'h12));
    finish_xfer("nack", d0, e0, 0, 1);

    // Reset after edge 5; bit 4 of 8'hED is 0, so data is held low at that point.
    send(PS2_CMD_SET_LED);
    dev_xfer(5, 1'b1, got, inh);
    check("mid_bits", got[4:0], 5'b01101);
    check("mid_data_driven", ps2_data, 0);
    #2 rst = 1'b0;
    #1;
    check("mid_rst_clk", ps2_clk, 1);
    check("mid_rst_data", ps2_data, 1);
    check("mid_rst_busy", tx_if.busy, 0);
    check("mid_rst_ready", tx_if.tx_ready, 1);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);

    d0 = cnt_done; e0 = cnt_err;
    send(PS2_CMD_ENABLE);
    dev_xfer(11, 1'b1, got, inh);
    check("f4_frame_lit", got, 10'h2F4);
    check("f4_frame_model", got, exp_frame(PS2_CMD_ENABLE));
    finish_xfer("f4", d0, e0, 1, 0);

    // Busy rejection: a second request during SHIFT must not disturb the frame.
    d0 = cnt_done; e0 = cnt_err;
    send(8'h3C);
    fork
      dev_xfer(11, 1'b1, got, inh);
      begin
        repeat (INH + 60) @(posedge clk);
        #1 tx_if.tx_data = 8'hAA;
        tx_if.tx_valid = 1'b1;
        @(posedge clk);
        #1 tx_if.tx_valid = 1'b0;
      end
    join
    check("rej_frame_lit", got, 10'h33C);
    check("rej_frame_model", got, exp_frame(8'h3C));
    finish_xfer("rej", d0, e0, 1, 0);

`ifdef PS2_TX_TIMEOUT_EN
    // No device: watchdog fires TO cycles after acceptance.
    d0 = cnt_done; e0 = cnt_err;
    send(PS2_CMD_ENABLE);
    begin
      int w;
      w = 0;
      while (cnt_err == e0 && w < int'(TO) + 200) begin
        @(negedge clk);
        w++;
      end
      if (w >= int'(TO) + 200) fail_bound("timeout_wait");
    end
    check("timeout_cycle", err_cyc, TO);
    @(negedge clk);
    check("timeout_ready", tx_if.tx_ready, 1);
    check("timeout_done_cnt", cnt_done - d0, 0);
    check("timeout_clk_rel", ps2_clk, 1);
    check("timeout_data_rel", ps2_data, 1);
`endif

    repeat (5) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/ps2_host_tx.md
# ps2_host_tx

Host-to-device transmitter for the PS/2 port. It sends one command byte, such as 8'hFF reset or 8'hED set-LEDs, from the FPGA to the keyboard. It uses the standard request-to-send sequence with odd parity and device acknowledge. It shares the open-drain PS2_CLK/PS2_DATA lines with the keyboard receive path and holds them only while a transfer is in progress.

## Interface
Parameters:
- INHIBIT_CYCLES, default 10000: clk cycles PS2_CLK is held low before start (100 µs at 100 MHz).
- TIMEOUT_CYCLES, default 2000000: watchdog limit per transfer (20 ms at 100 MHz).

Ports:
- clk  input  1  system clock, 100 MHz.
- rst  input  1  reset; asynchronous, active-low. One clock; the whole block is in the clk domain.
- tx_data  input  8  command byte.
- tx_valid  input  1  request to send tx_data.
- tx_ready  output  1  high when in IDLE; a byte is accepted when tx_valid && tx_ready.
- busy  output  1  high in every state except IDLE.
- tx_done  output  1  one-cycle pulse: byte sent and ACK received.
- tx_err  output  1  one-cycle pulse: NACK received, or watchdog expired.
- PS2_CLK  inout  1  open-drain; driven 0 or released (Z).
- PS2_DATA  inout  1  open-drain; driven 0 or released (Z).

## Operation
- Lines are only ever driven low or released; the block never drives 1.
- On accept, latch shift = {odd parity (~^tx_data), tx_data}.
- States:
  - IDLE: both lines released.
  - INHIBIT: PS2_CLK low for INHIBIT_CYCLES cycles.
  - RTS: PS2_DATA low, PS2_CLK released; wait for the first PS2_CLK falling edge.
  - SHIFT: drive the next bit on each falling edge.
  - ACK: sample the device acknowledge.
  - RECOVER: wait until both lines are high.
- Falling-edge count k (1..11):
  - k = 1..8: present data bit k-1, LSB first.
  - k = 9: present the parity bit.
  - k = 10: release PS2_DATA (stop bit).
  - k = 11: sample PS2_DATA. 0 means ACK and the block goes to RECOVER. 1 means NACK: tx_err pulses and the block goes to IDLE.
- Presenting a bit: value 1 releases PS2_DATA; value 0 drives it low.
- RECOVER to IDLE once synchronized PS2_CLK and PS2_DATA are both 1; tx_done pulses in that cycle.
- tx_valid is ignored while busy.
- tx_done and tx_err never pulse in the same cycle.
- Reset mid-transfer: both lines are released immediately (asynchronously). The state returns to IDLE and the edge count clears.
- No state is retained across reset.

## Timing
- Reset values: tx_ready = 1, busy = 0, tx_done = 0, tx_err = 0, PS2_CLK = Z, PS2_DATA = Z.
- Accept at edge N:
  - busy = 1 and PS2_CLK driven low from N+1.
  - PS2_DATA driven low after exactly INHIBIT_CYCLES cycles of inhibit.
  - PS2_CLK released one cycle after PS2_DATA goes low.
- Line inputs pass through a 2-flop synchronizer. A falling edge is detected on sync_prev = 1, sync = 0.
- The data line is updated 1 cycle after edge detect, 3 clk after the pin edge. This is well inside the device's roughly 30 µs low half-period.
- Back-to-back transfers: tx_ready returns 1 the cycle after tx_done or tx_err.

## Configuration
- PS2_TX_TIMEOUT_EN defined:
  - A counter runs in every non-IDLE state and resets on accept.
  - Reaching TIMEOUT_CYCLES releases both lines, pulses tx_err and goes to IDLE. This covers no device, a stuck clock, or a missing ACK.
- Not defined: no watchdog. The block waits indefinitely for device clocks, and tx_err fires only on NACK.

## Structure
- Package ps2_pkg:
  - state enum.
  - command constants: PS2_CMD_RESET = 8'hFF, PS2_CMD_SET_LED = 8'hED, PS2_CMD_ENABLE = 8'hF4, PS2_RSP_ACK = 8'hFA.
  - PS2_FRAME_EDGES = 11.
- One sub-module: ps2_line_sync. It holds the 2-flop synchronizers for both lines plus the PS2_CLK falling-edge pulse, and is reusable by the receive path.
- Counters: edge counter 4 bits; inhibit/timeout counter sized by $clog2 of the larger parameter.

## Test plan
- Send 8'hED with a device model that ACKs:
  - PS2_CLK is low for 10000 cycles before PS2_DATA falls.
  - Model samples bits 1,0,1,1,0,1,1,1 (LSB first), then parity 1 and stop 1.
  - Exactly one tx_done pulse; tx_err stays 0.
- Send 8'hFF: model samples parity 1, and tx_done pulses.
- Send 8'h00: model samples parity 1, and tx_done pulses.
- NACK: model holds PS2_DATA high on edge 11. Expect a tx_err pulse, no tx_done, and both lines released.
- With PS2_TX_TIMEOUT_EN, no device attached: expect tx_err exactly TIMEOUT_CYCLES after accept, then tx_ready = 1.
- Reset mid-transfer:
  - Assert rst low after edge 5. Both lines go Z without waiting for clk, and busy = 0.
  - After release, send 8'hF4; it completes with tx_done.
- Busy rejection: pulse tx_valid with 8'hAA during SHIFT. The byte is ignored and the in-flight byte completes unchanged.
